// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD display path.
//   NUM_DIGITS / BCD_W   : display width in digits / packed BCD bits
//   ST_IDLE / ST_SHIFT   : converter FSM encoding
//   OVERFLOW_*           : pattern shown when the value cannot be displayed
package bcd_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam logic [BCD_W-1:0]      OVERFLOW_DIGITS = 16'h9999;
   localparam logic [NUM_DIGITS-1:0] OVERFLOW_DP     = 4'b1111;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD nibble >= 5 so the
// following left shift carries correctly into the next decimal digit.
//   nibble    : BCD digit before the shift
//   corrected : digit after the add-3 correction
module bcd_add3 (
   input  logic [3:0] nibble,
   output logic [3:0] corrected
);

   assign corrected = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter feeding the seven-segment controller.
// Results are held between conversions so the display never sees a partial
// value.
//   clk, reset      : system clock, async active-high reset
//   start           : conversion request, honoured only when idle
//   value, dp_in    : operand and decimal-point pattern, captured with start
//   busy, done      : conversion in progress / one-cycle completion pulse
//   overflow        : last captured value exceeded MAX_VALUE
//   digits          : packed BCD result, [15:12] thousands .. [3:0] units
//   decimal_points  : decimal-point pattern for the displayed result
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | outputs hold last result; waiting for start
// ST_SHIFT | one add-3/shift step per clock, WIDTH steps in total
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int          WIDTH     = 14,
   parameter int unsigned MAX_VALUE = 9999
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   input  logic [NUM_DIGITS-1:0] dp_in,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [BCD_W-1:0]      digits,
   output logic [NUM_DIGITS-1:0] decimal_points
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [0:0]            state;
   logic [CNT_W-1:0]      count;
   logic [WIDTH-1:0]      binreg;
   logic [BCD_W-1:0]      scratch;
   logic [NUM_DIGITS-1:0] dp_cap;
   logic                  ovf_cap;

   logic [BCD_W-1:0]       corr;
   logic [BCD_W+WIDTH-1:0] shifted;
   logic [BCD_W-1:0]       scratch_next;
   logic                   last_step;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble    (scratch[4*g +: 4]),
         .corrected (corr[4*g +: 4])
      );
   end

   // Correct first, then shift the whole {scratch, binreg} pair as one word.
   assign shifted      = {corr, binreg} << 1;
   assign scratch_next = shifted[BCD_W+WIDTH-1:WIDTH];
   assign last_step    = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         count          <= '0;
         binreg         <= '0;
         scratch        <= '0;
         dp_cap         <= '0;
         ovf_cap        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         overflow       <= 1'b0;
         digits         <= '0;
         decimal_points <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  binreg  <= value;
                  scratch <= '0;
                  dp_cap  <= dp_in;
                  // Decide overflow now so the operand need not be kept.
                  ovf_cap <= (32'(value) > MAX_VALUE);
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scratch <= scratch_next;
               binreg  <= shifted[WIDTH-1:0];
               count   <= count + CNT_W'(1);
               if (last_step) begin
                  digits         <= ovf_cap ? OVERFLOW_DIGITS : scratch_next;
                  decimal_points <= ovf_cap ? OVERFLOW_DP : dp_cap;
                  overflow       <= ovf_cap;
                  done           <= 1'b1;
                  busy           <= 1'b0;
                  state          <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
